// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and sprite coordinate widths for the input-viewer renderers.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int SPR_COL_W = 10;
  localparam int SPR_ROW_W = 8;

  typedef logic [11:0] color_t;

  // True when lo <= v < lo + len.
  function automatic logic in_span(input int v, input int lo, input int len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stability counter; o_stable flips only after the
// synchronized input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_stable <= ~r_stable;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/dpad_left_renderer.sv
// D-pad-left sprite renderer: 3-stage pixel pipeline (address, ROM data, output) with
// frame-latched debounced button. Define DPAD_TINT_EN to replace pressed fill with TINT_COLOR.
module dpad_left_renderer
  import vga_pkg::*;
#(
  parameter int          IMG_W           = 584,
  parameter int          IMG_H           = 167,
  parameter int          ORIGIN_X        = 28,
  parameter int          ORIGIN_Y        = 160,
  parameter logic [11:0] BG_COLOR        = 12'h000,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [11:0] TINT_COLOR      = 12'hF80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        frame_start,
  input  logic        btn_left_raw,
  output logic [7:0]  rom_row,
  output logic [9:0]  rom_col,
  input  logic [11:0] fill_color,
  input  logic [11:0] outline_color,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        pressed
);

`ifdef DPAD_TINT_EN
  localparam logic TINT_ON = 1'b1;
`else
  localparam logic TINT_ON = 1'b0;
`endif

  localparam logic [9:0] ORG_X10 = 10'(ORIGIN_X);
  localparam logic [9:0] ORG_Y10 = 10'(ORIGIN_Y);

  logic                 w_in_box;
  logic [SPR_COL_W-1:0] w_col;
  logic [SPR_ROW_W-1:0] w_row;
  logic                 w_stable;
  color_t               w_fill_px;
  color_t               w_sprite_px;
  color_t               w_rgb_next;

  logic [SPR_ROW_W-1:0] r_rom_row;
  logic [SPR_COL_W-1:0] r_rom_col;
  logic                 r_in_box_a, r_video_a, r_hs_a, r_vs_a;
  logic                 r_in_box_b, r_video_b, r_hs_b, r_vs_b;
  color_t               r_rgb;
  logic                 r_hs_out, r_vs_out;
  logic                 r_pressed;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_left_raw),
    .o_stable(w_stable)
  );

  assign w_in_box = in_span(int'(pix_x), ORIGIN_X, IMG_W) && in_span(int'(pix_y), ORIGIN_Y, IMG_H);
  assign w_col    = pix_x - ORG_X10;
  assign w_row    = 8'(pix_y - ORG_Y10);

  always_comb begin
    w_fill_px   = TINT_ON ? TINT_COLOR : fill_color;
    w_sprite_px = outline_color;
    if (r_pressed && (fill_color != 12'h000)) begin
      w_sprite_px = w_fill_px;
    end
    w_rgb_next = 12'h000;
    if (r_video_b) begin
      w_rgb_next = r_in_box_b ? w_sprite_px : BG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rom_row  <= '0;
      r_rom_col  <= '0;
      r_in_box_a <= 1'b0;
      r_video_a  <= 1'b0;
      r_hs_a     <= 1'b1;
      r_vs_a     <= 1'b1;
      r_in_box_b <= 1'b0;
      r_video_b  <= 1'b0;
      r_hs_b     <= 1'b1;
      r_vs_b     <= 1'b1;
      r_rgb      <= 12'h000;
      r_hs_out   <= 1'b1;
      r_vs_out   <= 1'b1;
    end else begin
      // Out-of-box pixels park the ROM address at 0 so it never runs off the image.
      r_rom_row  <= w_in_box ? w_row : '0;
      r_rom_col  <= w_in_box ? w_col : '0;
      r_in_box_a <= w_in_box;
      r_video_a  <= video_on;
      r_hs_a     <= hsync_in;
      r_vs_a     <= vsync_in;
      r_in_box_b <= r_in_box_a;
      r_video_b  <= r_video_a;
      r_hs_b     <= r_hs_a;
      r_vs_b     <= r_vs_a;
      r_rgb      <= w_rgb_next;
      r_hs_out   <= r_hs_b;
      r_vs_out   <= r_vs_b;
    end
  end

  // Sampling the registered stable state gives the pre-flip value on a coincident flip.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pressed <= 1'b0;
    end else if (frame_start) begin
      r_pressed <= w_stable;
    end
  end

  assign rom_row   = r_rom_row;
  assign rom_col   = r_rom_col;
  assign rgb       = r_rgb;
  assign hsync_out = r_hs_out;
  assign vsync_out = r_vs_out;
  assign pressed   = r_pressed;

endmodule

// File: tb/tb_dpad_left_renderer.sv
// Randomized bench for dpad_left_renderer against a cycle-level behavioural model with ROM stand-ins.
module tb_dpad_left_renderer;

  localparam int          DB    = 4;
  localparam int          OX    = 28;
  localparam int          OY    = 160;
  localparam int          W     = 584;
  localparam int          H     = 167;
  localparam logic [11:0] BG    = 12'h0C3;
  localparam logic [11:0] TINT  = 12'hF80;

  typedef struct packed {
    logic       rst;
    logic       video;
    logic       hs;
    logic       vs;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] mode;
  } snap_t;

  localparam snap_t FLUSH = '{rst:1'b1, video:1'b0, hs:1'b1, vs:1'b1, x:10'd0, y:10'd0, mode:2'd0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pix_x = '0, pix_y = '0;
  logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
  logic        frame_start = 1'b0, btn_left_raw = 1'b0;
  logic [7:0]  rom_row;
  logic [9:0]  rom_col;
  logic [11:0] fill_color = '0, outline_color = '0, rgb;
  logic        hsync_out, vsync_out, pressed;
  logic [1:0]  fill_mode = 2'd0;

  int n_cmp = 0;
  int n_bad = 0;

  dpad_left_renderer #(
    .IMG_W(W), .IMG_H(H), .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .BG_COLOR(BG), .DEBOUNCE_CYCLES(DB), .TINT_COLOR(TINT)
  ) dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
    .btn_left_raw(btn_left_raw), .rom_row(rom_row), .rom_col(rom_col),
    .fill_color(fill_color), .outline_color(outline_color), .rgb(rgb),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .pressed(pressed)
  );

  always #5 clk = ~clk;

  // ROM contents: mode 0 = address hash with some zero texels, 1 = all white, 2 = all zero.
  function automatic logic [11:0] rom_fill(input int row, input int col, input logic [1:0] mode);
    logic [11:0] v;
    v = 12'((row * 37 + col * 11) % 4096);
    if (v[1:0] == 2'b00) v = 12'h000;
    if (mode == 2'd1) v = 12'hFFF;
    if (mode == 2'd2) v = 12'h000;
    return v;
  endfunction

  function automatic logic [11:0] rom_outline(input int row, input int col);
    return 12'((row * 5 + col * 3 + 1) % 4096) ^ 12'hA5A;
  endfunction

  always @(posedge clk) begin
    fill_color    <= rom_fill(int'(rom_row), int'(rom_col), fill_mode);
    outline_color <= rom_outline(int'(rom_row), int'(rom_col));
  end

  function automatic logic inside_sprite(input snap_t s);
    return int'(s.x) >= OX && int'(s.x) < OX + W && int'(s.y) >= OY && int'(s.y) < OY + H;
  endfunction

  function automatic logic [11:0] model_rgb(input snap_t s, input logic [1:0] mode, input logic prs);
    logic [11:0] f;
    if (s.rst || !s.video) return 12'h000;
    if (!inside_sprite(s)) return BG;
    f = rom_fill(int'(s.y) - OY, int'(s.x) - OX, mode);
    if (prs && f != 12'h000) begin
`ifdef DPAD_TINT_EN
      return TINT;
`else
      return f;
`endif
    end
    return rom_outline(int'(s.y) - OY, int'(s.x) - OX);
  endfunction

  task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: h1/h2 hold the input snapshots from one and two edges ago.
  snap_t       h1 = FLUSH, h2 = FLUSH, cur;
  logic        m_stable = 1'b0, m_pressed = 1'b0, m_d1 = 1'b0, m_d2 = 1'b0;
  int          m_run = 0;
  logic [11:0] e_rgb;
  logic        e_hs, e_vs, e_prs;
  logic [7:0]  e_row;
  logic [9:0]  e_col;

  always @(posedge clk) begin
    cur = '{rst:1'b0, video:video_on, hs:hsync_in, vs:vsync_in, x:pix_x, y:pix_y, mode:fill_mode};
    if (reset) begin
      e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1; e_row = '0; e_col = '0; e_prs = 1'b0;
      m_pressed = 1'b0; m_stable = 1'b0; m_run = 0; m_d1 = 1'b0; m_d2 = 1'b0;
      h1 = FLUSH; h2 = FLUSH;
    end else begin
      e_rgb = model_rgb(h2, h1.mode, m_pressed);
      e_hs  = h2.hs;
      e_vs  = h2.vs;
      e_row = inside_sprite(cur) ? 8'(int'(cur.y) - OY) : 8'd0;
      e_col = inside_sprite(cur) ? 10'(int'(cur.x) - OX) : 10'd0;
      if (frame_start) m_pressed = m_stable;
      if (m_d2 != m_stable) begin
        m_run++;
        if (m_run == DB) begin
          m_stable = ~m_stable;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_d2 = m_d1;
      m_d1 = btn_left_raw;
      e_prs = m_pressed;
      h2 = h1;
      h1 = cur;
    end
    #1;
    check_val("rgb", rgb, e_rgb);
    check_val("hsync_out", 12'(hsync_out), 12'(e_hs));
    check_val("vsync_out", 12'(vsync_out), 12'(e_vs));
    check_val("rom_row", 12'(rom_row), 12'(e_row));
    check_val("rom_col", 12'(rom_col), 12'(e_col));
    check_val("pressed", 12'(pressed), 12'(e_prs));
  end

  task automatic apply(input int x, input int y, input logic v, input logic fs, input logic b, input logic r);
    @(negedge clk);
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    video_on     = v;
    frame_start  = fs;
    btn_left_raw = b;
    reset        = r;
    hsync_in     = ($urandom % 4) != 0;
    vsync_in     = ($urandom % 8) != 0;
  endtask

  initial begin
    int hold;
    logic b;
    hold = 0;
    b = 1'b0;
    repeat (3) apply(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("phase: sprite corners and boundaries");
    apply(28, 160, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(611, 326, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(612, 326, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(611, 327, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(27, 160, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(300, 159, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(300, 250, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(100, 200, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("phase: debounced press, white fill then zero fill");
    fill_mode = 2'd1;
    for (int i = 0; i < 10; i++) apply(100 + i * 37, 200 + i, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(200, 200, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) apply(40 + i * 90, 170 + i * 20, 1'b1, 1'b0, 1'b1, 1'b0);
    fill_mode = 2'd2;
    for (int i = 0; i < 6; i++) apply(40 + i * 90, 170 + i * 20, 1'b1, 1'b0, 1'b1, 1'b0);
    fill_mode = 2'd0;
    for (int i = 0; i < 10; i++) apply(50 + i * 50, 180, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(60, 190, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(61, 190, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("phase: short glitch is rejected");
    apply(62, 190, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(63, 190, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) apply(64 + i, 190, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(80, 190, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply(81 + i, 190, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("phase: stable flip coincides with frame_start");
    for (int i = 0; i < 5; i++) apply(90 + i, 200, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(95, 200, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply(96 + i, 200, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(100, 200, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply(101 + i, 200, 1'b1, 1'b0, 1'b1, 1'b0);

    $display("phase: reset mid-line inside the sprite");
    apply(300, 200, 1'b1, 1'b0, 1'b1, 1'b0);
    apply(301, 200, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) apply(302 + i, 200, 1'b1, (i == 8), 1'b1, 1'b0);

    $display("phase: randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      int x, y;
      x = ($urandom % 2) != 0 ? int'($urandom_range(20, 620)) : int'($urandom_range(0, 799));
      y = ($urandom % 2) != 0 ? int'($urandom_range(150, 335)) : int'($urandom_range(0, 524));
      if (hold == 0) begin
        b = ($urandom % 2) != 0;
        hold = int'($urandom_range(1, 12));
      end
      hold--;
      if (($urandom % 60) == 0) fill_mode = 2'($urandom % 3);
      apply(x, y, ($urandom % 10) != 0, ($urandom % 40) == 0, b, ($urandom % 400) == 0);
    end
    repeat (4) apply(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
